// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the TinyMIPS multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [3:0] S_FETCH1  = 4'd0;
    localparam logic [3:0] S_FETCH2  = 4'd1;
    localparam logic [3:0] S_FETCH3  = 4'd2;
    localparam logic [3:0] S_FETCH4  = 4'd3;
    localparam logic [3:0] S_DECODE  = 4'd4;
    localparam logic [3:0] S_MEMADR  = 4'd5;
    localparam logic [3:0] S_LBRD    = 4'd6;
    localparam logic [3:0] S_LBWR    = 4'd7;
    localparam logic [3:0] S_SBWR    = 4'd8;
    localparam logic [3:0] S_RTYPEEX = 4'd9;
    localparam logic [3:0] S_RTYPEWR = 4'd10;
    localparam logic [3:0] S_BEQEX   = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_ADDIEX  = 4'd13;
    localparam logic [3:0] S_ADDIWR  = 4'd14;

    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Maps controller aluop and instruction funct to alucontrol.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB:   o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct values fall back to add
                case (i_funct)
                    FUNCT_ADD: o_alucontrol = ALU_ADD;
                    FUNCT_SUB: o_alucontrol = ALU_SUB;
                    FUNCT_AND: o_alucontrol = ALU_AND;
                    FUNCT_OR:  o_alucontrol = ALU_OR;
                    FUNCT_SLT: o_alucontrol = ALU_SLT;
                    default:   o_alucontrol = ALU_ADD;
                endcase
            end
            default:     o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_controller.sv
// ============================================================================
// Module      : mips_controller
// Description : Multicycle sequencer for the 8-bit TinyMIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       memtoreg,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       regdst,
    output logic       regwrite,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_memread, w_memwrite, w_alusrca, w_iord, w_memtoreg;
    logic       w_regdst, w_regwrite, w_pcwrite, w_pcwritecond, w_aluen;
    logic [1:0] w_alusrcb, w_pcsource, w_aluop;
    logic [3:0] w_irwrite;
    logic [2:0] w_alu_dec;

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (w_alu_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH1;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = S_FETCH1;
        w_memread     = 1'b0;
        w_memwrite    = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_iord        = 1'b0;
        w_irwrite     = 4'b0000;
        w_memtoreg    = 1'b0;
        w_pcsource    = 2'b00;
        w_regdst      = 1'b0;
        w_regwrite    = 1'b0;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_aluop       = ALUOP_ADD;
        w_aluen       = 1'b0;
        case (r_state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                w_memread = 1'b1;
                w_alusrcb = 2'b01;
                w_aluen   = 1'b1;
                w_pcwrite = 1'b1;
                w_irwrite = 4'b0001 << r_state[1:0];
                w_next    = (r_state == S_FETCH4) ? S_DECODE : r_state + 4'd1;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                w_aluen   = 1'b1;
                case (op)
                    OP_LB, OP_SB: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_FETCH1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_aluen   = 1'b1;
                w_next    = (op == OP_LB) ? S_LBRD : S_SBWR;
            end
            S_LBRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = S_LBWR;
            end
            S_LBWR: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_SBWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
                w_aluen   = 1'b1;
                w_next    = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca     = 1'b1;
                w_aluop       = ALUOP_SUB;
                w_aluen       = 1'b1;
                w_pcsource    = 2'b01;
                w_pcwritecond = 1'b1;
            end
            S_JEX: begin
                w_pcwrite  = 1'b1;
                w_pcsource = 2'b10;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_aluen   = 1'b1;
                w_next    = S_ADDIWR;
            end
            S_ADDIWR: begin
                w_regwrite = 1'b1;
            end
            default: w_next = S_FETCH1;
        endcase
    end

    // Reset gates every output so the datapath cannot be written mid-instruction
    assign memread    = ~reset & w_memread;
    assign memwrite   = ~reset & w_memwrite;
    assign alusrca    = ~reset & w_alusrca;
    assign alusrcb    = reset ? 2'b00 : w_alusrcb;
    assign iord       = ~reset & w_iord;
    assign irwrite    = reset ? 4'b0000 : w_irwrite;
    assign memtoreg   = ~reset & w_memtoreg;
    assign pcen       = ~reset & (w_pcwrite | (w_pcwritecond & zero));
    assign pcsource   = reset ? 2'b00 : w_pcsource;
    assign regdst     = ~reset & w_regdst;
    assign regwrite   = ~reset & w_regwrite;
    assign alucontrol = (reset | ~w_aluen) ? 3'b000 : w_alu_dec;
    assign state      = reset ? S_FETCH1 : r_state;

endmodule

`default_nettype wire

// File: doc/mips_controller.md
Name: mips_controller

Overview:
- Multicycle control unit for the 8-bit TinyMIPS core.
- Is the sequencing end of the datapath control interface: it takes opcode, funct and zero from the datapath, and drives every datapath select and enable line.
- Fetches each 32-bit instruction as four byte reads, then steps through the execute states for that instruction.
- Supported instructions: lb, sb, R-type (add/sub/and/or/slt), beq, j, addi.

Parameters:
- none; all opcode, funct and state encodings are fixed constants in mips_pkg.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from datapath
- funct  in  6  instr[5:0] from datapath
- zero  in  1  ALU zero flag from datapath
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0=PC, 1=register A
- alusrcb  out  2  00=B, 01=const 1, 10=imm, 11=imm (branch offset)
- iord  out  1  0=PC address, 1=ALUOut address
- irwrite  out  4  one-hot byte enable for the instruction register
- memtoreg  out  1  register write data: 0=ALUOut, 1=MDR
- pcen  out  1  PC register enable
- pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- regdst  out  1  write address: 0=rt, 1=rd
- regwrite  out  1  register file write enable
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state, for verification only

Behaviour:
- State machine:
  - One state register, clocked on the rising edge of clk.
  - When reset is high at a clock edge, the next state is FETCH1.
  - While reset is high, all outputs are forced to 0, including irwrite=0000 and pcen=0, so the datapath cannot be written.
  - After reset is released, the first FETCH1 is active on the first clock edge where reset is low.
- Outputs are decoded combinationally from state. pcen is Moore plus zero. alucontrol is Moore plus funct.
- Every signal not listed for a state is 0 in that state.
- pcen = pcwrite | (pcwritecond & zero).
- States, outputs and transitions:
  - FETCH1..FETCH4: memread=1, alusrcb=01, alucontrol=010, pcsource=00, pcwrite=1. irwrite=0001/0010/0100/1000 respectively. Next state is the following FETCH state; FETCH4 goes to DECODE. The PC advances by 1 on each fetch byte.
  - DECODE: alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by op:
    - 100000 (lb) or 101000 (sb) -> MEMADR
    - 000000 (R-type) -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 000010 (j) -> JEX
    - 001000 (addi) -> ADDIEX
    - any other op -> FETCH1 (executed as a NOP; no register or memory write).
  - MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Goes to LBRD if op=lb, else SBWR.
  - LBRD: memread=1, iord=1 -> LBWR.
  - LBWR: regwrite=1, memtoreg=1, regdst=0 -> FETCH1.
  - SBWR: memwrite=1, iord=1 -> FETCH1.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol taken from funct -> RTYPEWR.
    - funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
    - Any other funct -> 010.
  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0 -> FETCH1.
  - BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsource=01, pcwritecond=1 -> FETCH1.
  - JEX: pcwrite=1, pcsource=10 -> FETCH1.
  - ADDIEX: alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWR.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0 -> FETCH1.
- Instruction latency, in cycles from FETCH1 to the next FETCH1: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, illegal op 5.
- Boundaries and invariants:
  - zero is sampled only in BEQEX. zero=0 there gives pcen=0.
  - Reset asserted mid-instruction abandons the instruction: outputs are forced to 0 in that same cycle, and the state is FETCH1 after the edge.
  - irwrite is always one-hot or zero.
  - memread and memwrite are never both 1.
  - Unused state encodings go to FETCH1 with all outputs 0.

Decomposition:
- mips_pkg holds:
  - state encodings (4-bit localparams)
  - opcode constants: OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI
  - funct constants
  - alucontrol codes
  - 2-bit aluop codes: 00 add, 01 sub, 10 use funct
- One sub-module, alu_decoder: (aluop, funct) -> alucontrol, purely combinational. mips_controller drives aluop from the state and instantiates alu_decoder.

Test Plan:
- Reset held 2 cycles, then released:
  - During reset: state stays FETCH1 and all outputs are 0.
  - The next four cycles show irwrite 0001, 0010, 0100, 1000, each with pcen=1 and memread=1.
- op=000000, funct=100000: DECODE -> RTYPEEX (alucontrol=010, alusrca=1) -> RTYPEWR (regwrite=1, regdst=1) -> FETCH1. 7 cycles total.
- op=000100 (beq), run once with zero=1 and once with zero=0:
  - BEQEX drives alucontrol=110 and pcsource=01.
  - pcen=1 when zero=1; pcen=0 when zero=0.
  - FETCH1 follows in both cases.
- op=100000 (lb), then op=101000 (sb):
  - lb: MEMADR alusrcb=10 -> LBRD (iord=1, memread=1) -> LBWR (memtoreg=1, regwrite=1).
  - sb: SBWR (memwrite=1, iord=1).
  - memwrite is 0 throughout lb.
- op=111111 (illegal): DECODE -> FETCH1 with no regwrite or memwrite asserted. Then op=000010 (j): JEX gives pcen=1 and pcsource=10.
- Reset asserted during RTYPEEX with funct=100010:
  - Same cycle: outputs go to 0 (regwrite never pulses).
  - After the edge: state is FETCH1.
  - After release: fetch restarts with irwrite=0001.
